// File: rtl/fb_packetizer.sv
// fb_packetizer: turns accepted pixels and frame_done requests into two-word
// packets (header, data) for the frame-buffer interface FIFO.
module fb_packetizer #(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     px_valid,
    output logic                     px_ready,
    input  logic [$clog2(H_RES)-1:0] px_x,
    input  logic [$clog2(V_RES)-1:0] px_y,
    input  logic [23:0]              px_color,
    input  logic                     frame_done,
    input  logic                     fifo_full,
    output logic                     fifo_we,
    output logic [DATA_W-1:0]        fifo_wdata,
    output logic [1:0]               itf_packet_type,
    output logic [15:0]              frame_cnt,
    output logic                     oob_err
);

    typedef enum logic [2:0] {
        StIdle,
        StPxHdr,
        StPxData,
        StEofHdr,
        StEofData
    } state_e;

    localparam logic [1:0] TypeNone  = 2'b00;
    localparam logic [1:0] TypePixel = 2'b01;
    localparam logic [1:0] TypeEof   = 2'b10;

    state_e      state_q, state_d;
    logic        eof_pend_q, eof_pend_d;
    logic [29:0] addr_q, addr_d;
    logic [23:0] color_q, color_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        oob_err_q, oob_err_d;
    logic        px_in_range;
    logic        word_wr;
    logic [31:0] word;

    assign px_in_range = (32'(px_x) < H_RES) && (32'(px_y) < V_RES);

    // Word content depends only on registered state, so it stays put under fifo_full.
    always_comb begin
        px_ready        = (state_q == StIdle) && !eof_pend_q && !frame_done;
        word_wr         = (state_q != StIdle) && !fifo_full && !rst;
        word            = '0;
        itf_packet_type = TypeNone;
        unique case (state_q)
            StIdle: ;
            StPxHdr: begin
                word            = {TypePixel, addr_q};
                itf_packet_type = TypePixel;
            end
            StPxData: begin
                word            = {8'h00, color_q};
                itf_packet_type = TypePixel;
            end
            StEofHdr: begin
                word            = {TypeEof, 30'd0};
                itf_packet_type = TypeEof;
            end
            StEofData: begin
                word            = {16'h0000, frame_cnt_q};
                itf_packet_type = TypeEof;
            end
            default: ;
        endcase
    end

    assign fifo_we    = word_wr;
    assign fifo_wdata = DATA_W'(word);
    assign frame_cnt  = frame_cnt_q;
    assign oob_err    = oob_err_q;

    always_comb begin
        state_d     = state_q;
        eof_pend_d  = eof_pend_q | frame_done;
        addr_d      = addr_q;
        color_d     = color_q;
        frame_cnt_d = frame_cnt_q;
        oob_err_d   = oob_err_q;
        unique case (state_q)
            StIdle: begin
                // Entering EOF_HDR clears the pending flag and absorbs a coincident pulse.
                if (eof_pend_q) begin
                    state_d    = StEofHdr;
                    eof_pend_d = 1'b0;
                end else if (px_valid && px_ready) begin
                    addr_d  = 30'(px_y) * 30'(H_RES) + 30'(px_x);
                    color_d = px_color;
                    if (px_in_range) begin
                        state_d = StPxHdr;
                    end else begin
                        oob_err_d = 1'b1;
                    end
                end
            end
            StPxHdr:  if (word_wr) state_d = StPxData;
            StPxData: if (word_wr) state_d = StIdle;
            StEofHdr: if (word_wr) state_d = StEofData;
            StEofData: begin
                if (word_wr) begin
                    state_d     = StIdle;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            eof_pend_q  <= 1'b0;
            addr_q      <= '0;
            color_q     <= '0;
            frame_cnt_q <= '0;
            oob_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            eof_pend_q  <= eof_pend_d;
            addr_q      <= addr_d;
            color_q     <= color_d;
            frame_cnt_q <= frame_cnt_d;
            oob_err_q   <= oob_err_d;
        end
    end

endmodule

// File: tb/tb_fb_packetizer.sv
// Self-checking bench for fb_packetizer: vector table, cycle-level corner
// sequences, and randomized traffic against a packet-stream reference model.
module tb_fb_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        px_valid;
    logic        px_ready;
    logic [9:0]  px_x;
    logic [8:0]  px_y;
    logic [23:0] px_color;
    logic        frame_done;
    logic        fifo_full;
    logic        fifo_we;
    logic [31:0] fifo_wdata;
    logic [1:0]  itf_packet_type;
    logic [15:0] frame_cnt;
    logic        oob_err;

    fb_packetizer #(
        .H_RES (640),
        .V_RES (480),
        .DATA_W(32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .px_valid       (px_valid),
        .px_ready       (px_ready),
        .px_x           (px_x),
        .px_y           (px_y),
        .px_color       (px_color),
        .frame_done     (frame_done),
        .fifo_full      (fifo_full),
        .fifo_we        (fifo_we),
        .fifo_wdata     (fifo_wdata),
        .itf_packet_type(itf_packet_type),
        .frame_cnt      (frame_cnt),
        .oob_err        (oob_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [23:0] c;
        logic [31:0] hdr;
        logic [31:0] dat;
    } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] wq[$];
    int          eof_seen = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp_fc;
    logic        exp_oob;
    logic        acc;
    int          b;
    int          eof_iss;
    vec_t        tbl[5];

    // Every word the DUT writes, in order.
    always @(negedge clk) begin
        if (fifo_we === 1'b1) begin
            wq.push_back(fifo_wdata);
            if (fifo_wdata == 32'h8000_0000) eof_seen++;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a pixel and hold it until accepted; returns just after the handshake edge.
    task automatic send_px(input logic [9:0] x, input logic [8:0] y, input logic [23:0] c);
        int k;
        px_x = x; px_y = y; px_color = c; px_valid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (px_ready) break;
            @(posedge clk);
            #1;
        end
        check("send_px_ready", 32'(px_ready), 32'd1);
        @(posedge clk);
        #1;
        px_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{x: 10'd3,   y: 9'd2,   c: 24'h112233, hdr: 32'h4000_0503, dat: 32'h0011_2233};
        tbl[1] = '{x: 10'd639, y: 9'd479, c: 24'hC0FFEE, hdr: 32'h4004_AFFF, dat: 32'h00C0_FFEE};
        tbl[2] = '{x: 10'd0,   y: 9'd0,   c: 24'hABCDEF, hdr: 32'h4000_0000, dat: 32'h00AB_CDEF};
        tbl[3] = '{x: 10'd639, y: 9'd0,   c: 24'hFFFFFF, hdr: 32'h4000_027F, dat: 32'h00FF_FFFF};
        tbl[4] = '{x: 10'd0,   y: 9'd479, c: 24'h000001, hdr: 32'h4004_AD80, dat: 32'h0000_0001};

        rst = 1'b1; px_valid = 1'b0; px_x = '0; px_y = '0; px_color = '0;
        frame_done = 1'b0; fifo_full = 1'b0;
        exp_fc = 16'd0; exp_oob = 1'b0;

        // Reset values
        tick(3);
        @(negedge clk);
        check("rst_we_during", 32'(fifo_we), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rst_we", 32'(fifo_we), 32'd0);
        check("rst_wdata", fifo_wdata, 32'd0);
        check("rst_type", 32'(itf_packet_type), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_oob", 32'(oob_err), 32'd0);
        check("rst_ready", 32'(px_ready), 32'd1);
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < 5; i++) begin
            b = wq.size();
            send_px(tbl[i].x, tbl[i].y, tbl[i].c);
            tick(3);
            check("tbl_nwords", wq.size() - b, 32'd2);
            if (wq.size() >= b + 2) begin
                check("tbl_hdr", wq[b], tbl[i].hdr);
                check("tbl_data", wq[b+1], tbl[i].dat);
            end
        end

        // Single pixel, cycle by cycle
        px_x = 10'd3; px_y = 9'd2; px_color = 24'h112233; px_valid = 1'b1;
        @(negedge clk);
        check("sp_ready", 32'(px_ready), 32'd1);
        tick(1); px_valid = 1'b0;
        @(negedge clk);
        check("sp_hdr_we", 32'(fifo_we), 32'd1);
        check("sp_hdr", fifo_wdata, 32'h4000_0503);
        check("sp_hdr_type", 32'(itf_packet_type), 32'd1);
        tick(1);
        @(negedge clk);
        check("sp_data_we", 32'(fifo_we), 32'd1);
        check("sp_data", fifo_wdata, 32'h0011_2233);
        check("sp_data_type", 32'(itf_packet_type), 32'd1);
        tick(1);
        @(negedge clk);
        check("sp_idle_we", 32'(fifo_we), 32'd0);
        check("sp_idle_type", 32'(itf_packet_type), 32'd0);
        check("sp_ready_again", 32'(px_ready), 32'd1);
        tick(1);

        // Backpressure: fifo_full for the 3 cycles after accept
        b = wq.size();
        px_x = 10'd639; px_y = 9'd479; px_color = 24'hC0FFEE; px_valid = 1'b1;
        @(negedge clk);
        check("bp_ready", 32'(px_ready), 32'd1);
        tick(1); px_valid = 1'b0; fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stall_we", 32'(fifo_we), 32'd0);
            check("bp_stall_hold", fifo_wdata, 32'h4004_AFFF);
            tick(1);
        end
        fifo_full = 1'b0;
        @(negedge clk);
        check("bp_hdr_we", 32'(fifo_we), 32'd1);
        check("bp_hdr", fifo_wdata, 32'h4004_AFFF);
        tick(1);
        @(negedge clk);
        check("bp_data", fifo_wdata, 32'h00C0_FFEE);
        tick(3);
        check("bp_nwords", wq.size() - b, 32'd2);

        // frame_done together with px_valid: EOF first, then the pixel
        px_x = 10'd5; px_y = 9'd1; px_color = 24'h0A0B0C; px_valid = 1'b1; frame_done = 1'b1;
        @(negedge clk);
        check("sim_ready_fd", 32'(px_ready), 32'd0);
        tick(1); frame_done = 1'b0;
        @(negedge clk);
        check("sim_ready_pend", 32'(px_ready), 32'd0);
        tick(1);
        @(negedge clk);
        check("sim_eof_hdr_we", 32'(fifo_we), 32'd1);
        check("sim_eof_hdr", fifo_wdata, 32'h8000_0000);
        check("sim_eof_type", 32'(itf_packet_type), 32'd2);
        tick(1);
        @(negedge clk);
        check("sim_eof_data", fifo_wdata, {16'h0, exp_fc});
        check("sim_eof_data_type", 32'(itf_packet_type), 32'd2);
        tick(1);
        exp_fc = exp_fc + 16'd1;
        @(negedge clk);
        check("sim_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        check("sim_ready_after", 32'(px_ready), 32'd1);
        tick(1); px_valid = 1'b0;
        @(negedge clk);
        check("sim_px_hdr", fifo_wdata, 32'h4000_0285);
        tick(1);
        @(negedge clk);
        check("sim_px_data", fifo_wdata, 32'h000A_0B0C);
        tick(1);

        // frame_done in PX_DATA and again one cycle later: a single EOF
        b = wq.size();
        send_px(10'd7, 9'd3, 24'h445566);
        tick(1);
        frame_done = 1'b1;
        tick(1);
        tick(1); frame_done = 1'b0;
        tick(8);
        check("dfd_nwords", wq.size() - b, 32'd4);
        if (wq.size() >= b + 4) begin
            check("dfd_px_hdr", wq[b], 32'h4000_0787);
            check("dfd_px_data", wq[b+1], 32'h0044_5566);
            check("dfd_eof_hdr", wq[b+2], 32'h8000_0000);
            check("dfd_eof_data", wq[b+3], {16'h0, exp_fc});
        end
        exp_fc = exp_fc + 16'd1;
        check("dfd_frame_cnt", 32'(frame_cnt), 32'(exp_fc));

        // Out-of-range pixel
        b = wq.size();
        send_px(10'd640, 9'd0, 24'hDEAD00);
        tick(4);
        check("oob_nwords", wq.size() - b, 32'd0);
        check("oob_flag", 32'(oob_err), 32'd1);
        b = wq.size();
        send_px(10'd1, 9'd1, 24'h010203);
        tick(3);
        check("oob_next_nwords", wq.size() - b, 32'd2);
        if (wq.size() >= b + 2) begin
            check("oob_next_hdr", wq[b], 32'h4000_0281);
            check("oob_next_data", wq[b+1], 32'h0001_0203);
        end
        check("oob_sticky", 32'(oob_err), 32'd1);

        // rst in the cycle after the PX_HDR write
        b = wq.size();
        send_px(10'd2, 9'd0, 24'h778899);
        @(negedge clk);
        check("mid_hdr", fifo_wdata, 32'h4000_0002);
        tick(1); rst = 1'b1;
        @(negedge clk);
        check("mid_rst_we", 32'(fifo_we), 32'd0);
        tick(1); rst = 1'b0;
        exp_fc = 16'd0;
        @(negedge clk);
        check("mid_we", 32'(fifo_we), 32'd0);
        check("mid_wdata", fifo_wdata, 32'd0);
        check("mid_type", 32'(itf_packet_type), 32'd0);
        check("mid_frame_cnt", 32'(frame_cnt), 32'd0);
        check("mid_oob", 32'(oob_err), 32'd0);
        check("mid_ready", 32'(px_ready), 32'd1);
        tick(2);
        check("mid_nwords", wq.size() - b, 32'd1);
        b = wq.size();
        send_px(10'd4, 9'd4, 24'h123456);
        tick(3);
        check("mid_next_nwords", wq.size() - b, 32'd2);
        if (wq.size() >= b + 2) begin
            check("mid_next_hdr", wq[b], 32'h4000_0A04);
            check("mid_next_data", wq[b+1], 32'h0012_3456);
        end

        // Randomized traffic against the packet-stream model
        b = wq.size();
        eof_iss = eof_seen;
        exp_oob = 1'b0;
        for (int c = 0; c < 800; c++) begin
            fifo_full  = ($urandom_range(0, 3) == 0);
            frame_done = 1'b0;
            if (eof_seen == eof_iss && $urandom_range(0, 39) == 0) begin
                frame_done = 1'b1;
                eof_iss++;
            end
            if (!px_valid && $urandom_range(0, 1) == 0) begin
                px_x     = 10'($urandom_range(0, 660));
                px_y     = 9'($urandom_range(0, 495));
                px_color = 24'($urandom);
                px_valid = 1'b1;
            end
            @(negedge clk);
            if (frame_done) begin
                exp_q.push_back(32'h8000_0000);
                exp_q.push_back({16'h0, exp_fc});
                exp_fc = exp_fc + 16'd1;
            end
            acc = px_valid && px_ready;
            if (acc) begin
                if (px_x >= 10'd640 || px_y >= 9'd480) begin
                    exp_oob = 1'b1;
                end else begin
                    exp_q.push_back(32'h4000_0000 | (32'(px_y) * 32'd640 + 32'(px_x)));
                    exp_q.push_back({8'h00, px_color});
                end
            end
            @(posedge clk); #1;
            if (acc) px_valid = 1'b0;
        end
        px_valid = 1'b0; frame_done = 1'b0; fifo_full = 1'b0;
        for (int k = 0; k < 100 && (wq.size() - b) < exp_q.size(); k++) tick(1);
        tick(3);
        check("rnd_nwords", wq.size() - b, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (b + i < wq.size()) check("rnd_word", wq[b+i], exp_q[i]);
        end
        check("rnd_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        check("rnd_oob", 32'(oob_err), 32'(exp_oob));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_packetizer.md
# fb_packetizer

Transmit-side packet builder for the frame-buffer interface FIFO. It accepts shaded pixels from the ray-tracing core, converts each one into a two-word packet (header, then colour data), and pushes the words into the interface FIFO. The frame-buffer controller on the far side pops and decodes those packets. It also emits an end-of-frame packet on request and keeps a frame counter.

## Interface
- H_RES, 640, horizontal resolution in pixels
- V_RES, 480, vertical resolution in pixels
- DATA_W, 32, FIFO word width; must be ≥ 32
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- px_valid  in  1  pixel offered by the core
- px_ready  out  1  packetizer accepts the pixel this cycle
- px_x  in  $clog2(H_RES)  pixel column
- px_y  in  $clog2(V_RES)  pixel row
- px_color  in  24  RGB888 colour
- frame_done  in  1  single-cycle pulse: core has finished a frame
- fifo_full  in  1  interface FIFO cannot take a word
- fifo_we  out  1  write strobe to the interface FIFO
- fifo_wdata  out  DATA_W  word to the interface FIFO
- itf_packet_type  out  2  type of the packet in flight: 00 none, 01 PIXEL, 10 EOF, 11 reserved (never driven)
- frame_cnt  out  16  number of EOF packets completed
- oob_err  out  1  sticky flag: an out-of-range pixel was dropped

## Operation
- Packet format: the header word is `{type[1:0], addr[29:0]}` in bits 31:0, with upper bits zero when DATA_W > 32. The data word is `{8'h00, color}` for PIXEL and `{16'h0, frame_cnt}` for EOF (the value before the increment).
- PIXEL address: `addr = px_y*H_RES + px_x`, computed at accept time and zero-extended to 30 bits. EOF address is 0.
- States:
  - IDLE → EOF_HDR when an EOF is pending.
  - IDLE → PX_HDR on a pixel handshake with in-range coordinates.
  - PX_HDR → PX_DATA → IDLE.
  - EOF_HDR → EOF_DATA → IDLE.
  - HDR and DATA states advance only on a cycle where a word is written.
- Pixel accept:
  - `px_ready = (state==IDLE) && !eof_pend && !frame_done`.
  - A handshake (`px_valid && px_ready`) registers x, y, color and addr.
- Out-of-range pixel (`px_x ≥ H_RES` or `px_y ≥ V_RES`):
  - It is accepted and discarded; state stays IDLE.
  - oob_err sets and stays set until rst.
- frame_done:
  - Sets eof_pend whenever it pulses, in any state.
  - eof_pend clears on entry to EOF_HDR.
  - A second pulse while eof_pend is already set is absorbed: one EOF results.
- Ordering: every pixel accepted before frame_done is written before the EOF header. frame_done in the same cycle as px_valid wins; the pixel is not accepted and the core holds it.
- Writing:
  - In any HDR or DATA state, `fifo_we = !fifo_full`, and fifo_wdata carries that state's word.
  - fifo_we is 0 in IDLE.
  - While fifo_full is high, fifo_wdata is held stable.
- frame_cnt increments, wrapping at 16'hFFFF → 0, in the cycle the EOF data word is written.
- itf_packet_type:
  - 01 in PX_HDR and PX_DATA.
  - 10 in EOF_HDR and EOF_DATA.
  - 00 in IDLE.
  - It is a combinational decode of the state register.

## Timing
- Reset values: state IDLE, eof_pend 0, fifo_we 0, fifo_wdata 0, itf_packet_type 00, frame_cnt 0, oob_err 0. px_ready is high in the cycle after rst deasserts.
- Pixel latency: handshake in cycle N → header written in cycle N+1 → data written in N+2 (no backpressure) → px_ready high again in N+3. Peak throughput is 1 pixel per 3 cycles.
- EOF: pend set in N → header in N+1 if IDLE → data in N+2. frame_cnt shows the new value in N+3.
- Backpressure: each cycle with fifo_full high inserts exactly one stall cycle in the current state. No word is dropped or duplicated.
- rst mid-packet: all state returns to reset values on the next edge and the partial packet is abandoned. fifo_we is 0 in the cycle rst is sampled high.

## Test plan
- Single pixel: x=3, y=2, color=24'h112233, fifo_full=0 → two consecutive writes, 32'h4000_0503 then 32'h0011_2233. itf_packet_type reads 01 for both cycles, then 00.
- Backpressure: pixel x=639, y=479 with fifo_full high for the 3 cycles after accept → header 32'h4004_AFFF is held stable and written on the 4th cycle; data follows; exactly 2 writes occur.
- Simultaneous frame_done and px_valid in IDLE → EOF written first (32'h8000_0000, then 32'h0000_0000); frame_cnt becomes 1; the pixel packet follows.
- frame_done pulsed during PX_DATA, and again one cycle later → the pixel completes, then exactly one EOF packet is written; frame_cnt increments by 1.
- Out-of-range pixel x=640 → no FIFO writes; oob_err=1 and stays set through later valid traffic; the next valid pixel is handled normally.
- rst asserted in the cycle after a PX_HDR write → no data word is written; all outputs take their reset values; a subsequent pixel completes normally.
